// File: rtl/full_handshake_tx_arb.sv
// rtl/full_handshake_tx_arb.sv - round-robin arbiter and four-phase req/ack transmit controller
module full_handshake_tx_arb #(
  parameter int DW   = 32,
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      src_valid_i,
  input  logic [NREQ*DW-1:0]   src_data_i,
  output logic [NREQ-1:0]      src_ready_o,
  output logic                 req_o,
  output logic [DW-1:0]        req_data_o,
  output logic [IW-1:0]        req_id_o,
  input  logic                 ack_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [IW-1:0]        done_id_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    ASSERT   = 3'b010,
    DEASSERT = 3'b100
  } state_t;

  state_t            state;
  logic              ack_m;
  logic              ack_s;
  logic [IW-1:0]     last;
  logic              grant_any;
  logic [IW-1:0]     grant_idx;
  logic [IW-1:0]     idx;
  logic [NREQ-1:0]   grant_onehot;
  logic [DW-1:0]     grant_data;

  assign busy_o = (state != IDLE);

  // Two-flop synchroniser for the asynchronous acknowledge; only ack_s is used below
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= ack_i;
      ack_s <= ack_m;
    end
  end

  // Round-robin search: first valid source after the last winner, wrapping at NREQ
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = last;
    for (int i = 0; i < NREQ; i++) begin
      if (idx == IW'(NREQ - 1)) idx = '0;
      else                      idx = idx + IW'(1);
      if (!grant_any && src_valid_i[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Select the winner's data word and build its one-hot ready vector
  always_comb begin
    grant_data   = '0;
    grant_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IW'(k)) begin
        grant_data      = src_data_i[k*DW +: DW];
        grant_onehot[k] = 1'b1;
      end
    end
  end

  // Handshake sequencer: grant in IDLE, hold req until ack, drop req until ack clears
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      src_ready_o <= '0;
      req_o       <= 1'b0;
      req_data_o  <= '0;
      req_id_o    <= '0;
      done_o      <= 1'b0;
      done_id_o   <= '0;
      last        <= IW'(NREQ - 1);
    end else begin
      src_ready_o <= '0;
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          // A stale high ack from the receiver must clear before a new request starts
          if (grant_any && !ack_s) begin
            src_ready_o <= grant_onehot;
            req_data_o  <= grant_data;
            req_id_o    <= grant_idx;
            req_o       <= 1'b1;
            last        <= grant_idx;
            state       <= ASSERT;
          end
        end
        ASSERT: begin
          if (ack_s) begin
            req_o <= 1'b0;
            state <= DEASSERT;
          end
        end
        DEASSERT: begin
          if (!ack_s) begin
            done_o    <= 1'b1;
            done_id_o <= req_id_o;
            state     <= IDLE;
          end
        end
        default: begin
          req_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
